sd_block_writer: RTL and testbench
==================================

# sd_block_writer

SPI-mode SD card single-block writer (CMD24), the write-side counterpart of the SD block reader. Sits beside `SDCardInitializer` behind the top-level MOSI mux, runs on the divided SD clock (`d_clock`), and drains exactly 512 bytes from a first-word-fall-through FIFO into one card sector. It reports completion and a failure code.

## Interface
- `R1_TIMEOUT`, default 8: max response bytes polled for R1 and for the data-response token.
- `BUSY_TIMEOUT`, default 65535: max bytes polled while the card holds MISO low (programming busy).
- `clock`  in  1  SD bit clock; all state advances on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  level; sampled only in IDLE.
- `block_addr`  in  32  CMD24 argument; captured on the start cycle.
- `data_in`  in  8  FIFO head byte; valid while `data_valid` is high.
- `data_valid`  in  1  FIFO not empty.
- `data_pop`  out  1  one-cycle pulse; consumes `data_in`.
- `MISO`  in  1  card data out.
- `MOSI`  out  1  card data in, MSB first.
- `CS`  out  1  card select, active-low.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a transaction, on success or failure.
- `error`  out  1  transaction failed; valid with `done`, held until the next start.
- `error_code`  out  3  1 R1 timeout, 2 R1 nonzero, 3 FIFO underrun, 4 data rejected, 5 busy timeout; 0 on success.

## Operation
- Byte engine: 8-bit TX shift register, 8-bit RX shift register, 3-bit bit counter. MOSI presents TX[7]. RX shifts in MISO every cycle. A byte completes when the counter wraps 7→0.
- States, each one or more whole bytes:
  - IDLE: CS=1, MOSI=1. `start` → CMD.
  - CMD: 6 bytes: 0x58, addr[31:24], [23:16], [15:8], [7:0], 0xFF. → R1.
  - R1: send 0xFF and check each received byte.
    - First byte with bit7=0: 0x00 → GAP. Any other value → ERR, code 2.
    - `R1_TIMEOUT` bytes with bit7=1 → ERR, code 1.
  - GAP: one 0xFF byte. → TOKEN.
  - TOKEN: 0xFE. → DATA.
  - DATA: 512 bytes. At each byte load:
    - If `data_valid`=1: pulse `data_pop` and load `data_in`.
    - If `data_valid`=0: → ERR, code 3. No pop.
    - 9-bit byte counter; 511→0 wrap → CRC.
  - CRC: 2 bytes 0xFF. → RESP.
  - RESP: send 0xFF and check each received byte.
    - First byte with bit4=0: (b & 0x1F)==0x05 → BUSY. Any other value → ERR, code 4.
    - `R1_TIMEOUT` bytes with bit4=1 → ERR, code 1.
  - BUSY: send 0xFF until a received byte equals 0xFF → FINISH. `BUSY_TIMEOUT` bytes without 0xFF → ERR, code 5.
  - ERR: latch `error`=1 and `error_code`. → FINISH.
  - FINISH: CS=1, one 0xFF byte (8 trailing clocks). Pulse `done`. → IDLE.
- Timeout counters are 16 bits and clear on every state entry.
- `start` held high through `done` starts a new transaction on the cycle after IDLE is re-entered.

## Timing
- Reset values: MOSI=1, CS=1, busy=0, done=0, data_pop=0, error=0, error_code=0, all counters 0, state IDLE.
- Start cycle (IDLE, `start`=1): capture `block_addr`, clear `error`/`error_code`, load 0x58. On the next cycle CS=0 and MOSI=0 (bit7 of 0x58).
- Each byte lasts exactly 8 cycles. A state decision is made on the cycle RX holds the full byte, and the next byte starts the following cycle. There are no idle cycles between bytes.
- `data_pop` is asserted on the cycle the new TX byte is loaded; `data_in` is sampled in that same cycle.
- Minimum successful transaction: 48+8+8+8+4096+16+8+8+8 = 4208 cycles from CS falling to the `done` cycle. Each extra poll byte adds 8 cycles.
- `done` is high for exactly one cycle, the last cycle of FINISH. `busy` falls the cycle after.
- Reset mid-transaction immediately forces all reset values. No `done` is produced, and FIFO bytes already popped are lost.

## Test plan
- Nominal: addr=0x00000010, card R1=0x00 after 1 byte, response 0xE5, busy 3 bytes. Required: MOSI carries 58 00 00 00 10 FF, then FF, FE, bytes 0..511, FF FF. 512 `data_pop` pulses. `done` with error=0 at 4208+24 cycles.
- R1 never arrives (MISO=1): `done` after FINISH, error=1, code=1, CS=1, zero pops.
- R1=0x04: error code 2, zero pops.
- Underrun: FIFO holds 300 bytes. Required: exactly 300 pops, error code 3, `done` pulses.
- Data rejected, response 0x0B: error code 4. Busy never released with `BUSY_TIMEOUT`=4: error code 5 after 4 busy bytes.
- Reset asserted at data byte 100: CS=1, MOSI=1 and busy=0 asynchronously, no `done`. A following `start` runs a clean nominal transaction.

Source files
------------

// File: rtl/sd_block_writer.sv
// sd_block_writer
// SPI-mode SD card single-block writer (CMD24). It runs on the divided SD clock
// and moves exactly 512 bytes from a first-word-fall-through FIFO into one card
// sector. When the transaction ends it pulses done and reports an error code.
//
// Ports
//   clock       SD bit clock. All state advances on the rising edge.
//   reset       Asynchronous, active-high.
//   start       Level request. It is sampled only in IDLE.
//   block_addr  CMD24 argument. Captured on the start cycle.
//   data_in     FIFO head byte. Valid while data_valid is high.
//   data_valid  FIFO not empty.
//   data_pop    One-cycle pulse that consumes data_in.
//   MISO        Card data out.
//   MOSI        Card data in, MSB first.
//   CS          Card select, active-low.
//   busy        High in every state except IDLE.
//   done        One-cycle pulse on the last cycle of a transaction.
//   error       The transaction failed. Held until the next start.
//   error_code  1 R1 timeout, 2 R1 nonzero, 3 FIFO underrun, 4 data rejected,
//               5 busy timeout, 0 success.
module sd_block_writer #(
  parameter int R1_TIMEOUT   = 8,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] block_addr,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_pop,
  input  logic        MISO,
  output logic        MOSI,
  output logic        CS,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  error_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA,
    S_CRC, S_RESP, S_BUSY, S_ERR, S_FINISH
  } state_t;

  localparam logic [15:0] R1_LAST   = 16'(R1_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  tx, tx_next;
  logic [6:0]  rx;
  logic [2:0]  bit_cnt;
  logic [8:0]  byte_cnt, byte_cnt_next;
  logic [15:0] to_cnt;
  logic [31:0] addr;
  logic        byte_end, load, capture, to_inc, set_err;
  logic [2:0]  code_next;
  logic [7:0]  rx_byte;

  // The decision cycle of a byte is its eighth bit. At that point the
  // complete received byte is the seven stored bits plus the live MISO bit.
  // This lets the next TX byte load on the same edge, with no gap cycle.
  assign byte_end = (bit_cnt == 3'd7);
  assign rx_byte  = {rx, MISO};

  assign MOSI = (state == S_IDLE) ? 1'b1 : tx[7];
  assign CS   = (state == S_IDLE) || (state == S_ERR) || (state == S_FINISH);
  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH) && byte_end;

  // Next-state logic. Every decision happens at a byte boundary and selects
  // the next byte to shift out.
  always_comb begin
    state_next    = state;
    load          = 1'b0;
    tx_next       = 8'hFF;
    byte_cnt_next = byte_cnt;
    capture       = 1'b0;
    to_inc        = 1'b0;
    set_err       = 1'b0;
    code_next     = 3'd0;
    data_pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next    = S_CMD;
          load          = 1'b1;
          tx_next       = 8'h58;
          byte_cnt_next = 9'd0;
          capture       = 1'b1;
        end
      end
      S_CMD: begin
        if (byte_end) begin
          load = 1'b1;
          if (byte_cnt == 9'd5) begin
            state_next    = S_R1;
            byte_cnt_next = 9'd0;
          end else begin
            byte_cnt_next = byte_cnt + 9'd1;
            case (byte_cnt)
              9'd0:    tx_next = addr[31:24];
              9'd1:    tx_next = addr[23:16];
              9'd2:    tx_next = addr[15:8];
              9'd3:    tx_next = addr[7:0];
              default: tx_next = 8'hFF;
            endcase
          end
        end
      end
      S_R1: begin
        if (byte_end) begin
          load = 1'b1;
          if (!rx_byte[7]) begin
            if (rx_byte == 8'h00) begin
              state_next = S_GAP;
            end else begin
              state_next = S_ERR;
              set_err    = 1'b1;
              code_next  = 3'd2;
            end
          end else if (to_cnt == R1_LAST) begin
            state_next = S_ERR;
            set_err    = 1'b1;
            code_next  = 3'd1;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (byte_end) begin
          load       = 1'b1;
          tx_next    = 8'hFE;
          state_next = S_TOKEN;
        end
      end
      S_TOKEN: begin
        if (byte_end) begin
          load = 1'b1;
          if (data_valid) begin
            state_next    = S_DATA;
            data_pop      = 1'b1;
            tx_next       = data_in;
            byte_cnt_next = 9'd0;
          end else begin
            state_next = S_ERR;
            set_err    = 1'b1;
            code_next  = 3'd3;
          end
        end
      end
      S_DATA: begin
        if (byte_end) begin
          load = 1'b1;
          if (byte_cnt == 9'd511) begin
            state_next    = S_CRC;
            byte_cnt_next = 9'd0;
          end else if (data_valid) begin
            data_pop      = 1'b1;
            tx_next       = data_in;
            byte_cnt_next = byte_cnt + 9'd1;
          end else begin
            state_next = S_ERR;
            set_err    = 1'b1;
            code_next  = 3'd3;
          end
        end
      end
      S_CRC: begin
        if (byte_end) begin
          load = 1'b1;
          if (byte_cnt == 9'd1) begin
            state_next    = S_RESP;
            byte_cnt_next = 9'd0;
          end else begin
            byte_cnt_next = byte_cnt + 9'd1;
          end
        end
      end
      S_RESP: begin
        if (byte_end) begin
          load = 1'b1;
          if (!rx_byte[4]) begin
            if (rx_byte[4:0] == 5'h05) begin
              state_next = S_BUSY;
            end else begin
              state_next = S_ERR;
              set_err    = 1'b1;
              code_next  = 3'd4;
            end
          end else if (to_cnt == R1_LAST) begin
            state_next = S_ERR;
            set_err    = 1'b1;
            code_next  = 3'd1;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (byte_end) begin
          load = 1'b1;
          if (rx_byte == 8'hFF) begin
            state_next = S_FINISH;
          end else if (to_cnt == BUSY_LAST) begin
            state_next = S_ERR;
            set_err    = 1'b1;
            code_next  = 3'd5;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (byte_end) begin
          load       = 1'b1;
          state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        if (byte_end) begin
          load       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and byte engine. The bit counter is held at zero in IDLE,
  // so the first command byte begins cleanly on the cycle after start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tx         <= 8'hFF;
      rx         <= 7'd0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 9'd0;
      to_cnt     <= 16'd0;
      addr       <= 32'd0;
      error      <= 1'b0;
      error_code <= 3'd0;
    end else begin
      state    <= state_next;
      rx       <= rx_byte[6:0];
      bit_cnt  <= (state == S_IDLE) ? 3'd0 : bit_cnt + 3'd1;
      tx       <= load ? tx_next : {tx[6:0], 1'b1};
      byte_cnt <= byte_cnt_next;
      // Poll counters restart whenever a new state is entered.
      if (state_next != state) begin
        to_cnt <= 16'd0;
      end else if (to_inc) begin
        to_cnt <= to_cnt + 16'd1;
      end
      if (capture) begin
        addr       <= block_addr;
        error      <= 1'b0;
        error_code <= 3'd0;
      end
      if (set_err) begin
        error      <= 1'b1;
        error_code <= code_next;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_writer.sv
// tb_sd_block_writer
// Scoreboard bench for sd_block_writer. A scripted card model drives MISO and
// a FIFO model feeds bytes 0,1,2,... Each scenario pushes its expected MOSI
// bytes and its expected completion record into queues. A monitor process
// pops from those queues and compares as the DUT produces bytes and done.
module tb_sd_block_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] block_addr = 32'd0;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid = 1'b0;
  logic        data_pop;
  logic        MISO = 1'b1;
  logic        MOSI, CS, busy, done, error;
  logic [2:0]  error_code;

  always #5 clock = ~clock;

  sd_block_writer #(.R1_TIMEOUT(8), .BUSY_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .block_addr(block_addr),
    .data_in(data_in), .data_valid(data_valid), .data_pop(data_pop),
    .MISO(MISO), .MOSI(MOSI), .CS(CS), .busy(busy), .done(done),
    .error(error), .error_code(error_code)
  );

  typedef struct {
    logic       err;
    logic [2:0] code;
    int         cycles;
    int         pops;
  } result_t;

  logic [7:0] exp_bytes[$];
  result_t    exp_results[$];
  int total = 0;
  int bad = 0;

  // Card script and FIFO model state.
  logic [7:0] r1_val = 8'h00;
  bit         r1_never = 1'b0;
  logic [7:0] resp_val = 8'hE5;
  int         busy_n = 0;
  bit         busy_never = 1'b0;
  int         fifo_n = 0;
  int         fifo_idx = 0;
  int         txn_pops = 0;
  int         done_count = 0;
  bit         pop_seen = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // The card's reply for host byte k, counted from CS falling.
  function automatic logic [7:0] card_byte(input int k);
    if (r1_never || k < 6) return 8'hFF;
    if (k == 6) return r1_val;
    if (k < 523) return 8'hFF;
    if (k == 523) return resp_val;
    if (busy_never || k < 524 + busy_n) return 8'h00;
    return 8'hFF;
  endfunction

  task automatic push_stream(input logic [31:0] addr, input int r1_polls, input bit gap_token,
                             input int data_n, input bit tail, input int busy_bytes);
    exp_bytes.push_back(8'h58);
    exp_bytes.push_back(addr[31:24]);
    exp_bytes.push_back(addr[23:16]);
    exp_bytes.push_back(addr[15:8]);
    exp_bytes.push_back(addr[7:0]);
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < r1_polls; i++) exp_bytes.push_back(8'hFF);
    if (gap_token) begin
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'hFE);
    end
    for (int i = 0; i < data_n; i++) exp_bytes.push_back(8'(i));
    if (tail) begin
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'hFF);
    end
    for (int i = 0; i < busy_bytes; i++) exp_bytes.push_back(8'hFF);
  endtask

  task automatic push_result(input logic err, input logic [2:0] code, input int cycles, input int pops);
    result_t r;
    r.err = err;
    r.code = code;
    r.cycles = cycles;
    r.pops = pops;
    exp_results.push_back(r);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input int fifo_bytes, input logic [7:0] r1,
                                input bit r1_none, input logic [7:0] resp, input int busy_bytes,
                                input bit busy_stuck);
    @(negedge clock);
    r1_val = r1;
    r1_never = r1_none;
    resp_val = resp;
    busy_n = busy_bytes;
    busy_never = busy_stuck;
    fifo_n = fifo_bytes;
    fifo_idx = 0;
    txn_pops = 0;
    start = 1'b1;
    block_addr = addr;
    @(negedge clock);
    start = 1'b0;
    block_addr = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input int limit);
    int base;
    int n;
    base = done_count;
    n = 0;
    while (done_count == base && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (done_count == base) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", limit);
    end
    repeat (3) @(negedge clock);
  endtask

  // Monitor and models. Everything runs on the falling edge, away from the
  // DUT's sampling edge.
  initial begin : monitor
    int bit_idx;
    int cyc;
    bit in_txn;
    bit busy_chk;
    logic [7:0] cur;
    logic [7:0] host;
    result_t r;
    bit_idx = 0;
    cyc = 0;
    in_txn = 1'b0;
    busy_chk = 1'b0;
    cur = 8'hFF;
    host = 8'h00;
    forever begin
      @(negedge clock);
      if (pop_seen) begin
        fifo_idx++;
        pop_seen = 1'b0;
      end
      if (data_pop) begin
        pop_seen = 1'b1;
        txn_pops++;
      end
      data_valid = (fifo_idx < fifo_n);
      data_in = 8'(fifo_idx);
      if (busy_chk) begin
        check_output("busy_after_done", 32'(busy), 32'd0);
        busy_chk = 1'b0;
      end
      if (reset) begin
        bit_idx = 0;
        in_txn = 1'b0;
        MISO = 1'b1;
      end else begin
        if (!in_txn && !CS) begin
          in_txn = 1'b1;
          cyc = 1;
        end else if (in_txn) begin
          cyc++;
        end
        if (CS) begin
          bit_idx = 0;
          MISO = 1'b1;
        end else begin
          if (bit_idx % 8 == 0) cur = card_byte(bit_idx / 8);
          MISO = cur[7 - (bit_idx % 8)];
          host = {host[6:0], MOSI};
          bit_idx++;
          if (bit_idx % 8 == 0) begin
            if (exp_bytes.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL mosi_extra: got 0x%0h, want no byte", host);
            end else begin
              check_output($sformatf("mosi_byte%0d", bit_idx / 8 - 1), 32'(host), 32'(exp_bytes.pop_front()));
            end
          end
        end
        if (done) begin
          done_count++;
          if (exp_results.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL done_unexpected: got done=1, want 0");
          end else begin
            r = exp_results.pop_front();
            check_output("done_error", 32'(error), 32'(r.err));
            check_output("done_code", 32'(error_code), 32'(r.code));
            check_output("done_cycles", 32'(cyc), 32'(r.cycles));
            check_output("done_pops", 32'(txn_pops), 32'(r.pops));
            check_output("done_cs", 32'(CS), 32'd1);
            check_output("bytes_left", 32'(exp_bytes.size()), 32'd0);
          end
          in_txn = 1'b0;
          busy_chk = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int saved_done;
    $display("[TB] sd_block_writer bench start");
    repeat (3) @(negedge clock);
    check_output("rst_mosi", 32'(MOSI), 32'd1);
    check_output("rst_cs", 32'(CS), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_pop", 32'(data_pop), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_code", 32'(error_code), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Nominal: R1 on first poll, response E5, three busy bytes and then release.
    push_stream(32'h0000_0010, 1, 1'b1, 512, 1'b1, 4);
    push_result(1'b0, 3'd0, 4232, 512);
    apply_stimulus(32'h0000_0010, 512, 8'h00, 1'b0, 8'hE5, 3, 1'b0);
    wait_done(6000);

    // R1 never arrives: eight polls, then a timeout.
    push_stream(32'h1234_5678, 8, 1'b0, 0, 1'b0, 0);
    push_result(1'b1, 3'd1, 128, 0);
    apply_stimulus(32'h1234_5678, 512, 8'h00, 1'b1, 8'hE5, 0, 1'b0);
    wait_done(6000);
    check_output("error_held", 32'(error), 32'd1);

    // R1 = 0x04 is rejected.
    push_stream(32'h8000_0001, 1, 1'b0, 0, 1'b0, 0);
    push_result(1'b1, 3'd2, 72, 0);
    apply_stimulus(32'h8000_0001, 512, 8'h04, 1'b0, 8'hE5, 0, 1'b0);
    wait_done(6000);

    // FIFO underrun after 300 bytes.
    push_stream(32'h00FF_0100, 1, 1'b1, 300, 1'b0, 0);
    push_result(1'b1, 3'd3, 2488, 300);
    apply_stimulus(32'h00FF_0100, 300, 8'h00, 1'b0, 8'hE5, 0, 1'b0);
    wait_done(6000);

    // Data response 0x0B is rejected.
    push_stream(32'h0000_0200, 1, 1'b1, 512, 1'b1, 0);
    push_result(1'b1, 3'd4, 4208, 512);
    apply_stimulus(32'h0000_0200, 512, 8'h00, 1'b0, 8'h0B, 0, 1'b0);
    wait_done(6000);

    // Card never releases busy. With BUSY_TIMEOUT=4 the error comes after four bytes.
    push_stream(32'h0000_0300, 1, 1'b1, 512, 1'b1, 4);
    push_result(1'b1, 3'd5, 4240, 512);
    apply_stimulus(32'h0000_0300, 512, 8'h00, 1'b0, 8'hE5, 0, 1'b1);
    wait_done(6000);

    // Reset in the middle of the data phase.
    push_stream(32'h0000_0010, 1, 1'b1, 512, 1'b1, 4);
    apply_stimulus(32'h0000_0010, 512, 8'h00, 1'b0, 8'hE5, 3, 1'b0);
    n = 0;
    while (txn_pops < 100 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check_output("pops_before_reset", 32'(txn_pops >= 100), 32'd1);
    repeat (3) @(negedge clock);
    saved_done = done_count;
    #1 reset = 1'b1;
    #1;
    check_output("midrst_cs", 32'(CS), 32'd1);
    check_output("midrst_mosi", 32'(MOSI), 32'd1);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_pop", 32'(data_pop), 32'd0);
    repeat (2) @(negedge clock);
    #1;
    exp_bytes.delete();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_output("midrst_no_done", 32'(done_count), 32'(saved_done));
    check_output("midrst_error", 32'(error), 32'd0);

    // A clean transaction after the reset, with a different address.
    push_stream(32'hA5C3_1E07, 1, 1'b1, 512, 1'b1, 4);
    push_result(1'b0, 3'd0, 4232, 512);
    apply_stimulus(32'hA5C3_1E07, 512, 8'h00, 1'b0, 8'hE5, 3, 1'b0);
    wait_done(6000);
    check_output("results_left", 32'(exp_results.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
